// File: rtl/dds_mc_pkg.sv
// dds_mc_pkg: shared constants and helpers for the multi-channel NCO.
//   OW_DEF/AW_DEF : default output width / LUT address width
//   QUARTER       : quarter-cycle LUT offset for the default AW
//   ch_width()    : channel index width, never below 1
//   lut_val()     : rounded cosine table entry, amplitude 2^(ow-1)-1
package dds_mc_pkg;
    localparam int  OW_DEF  = 18;
    localparam int  AW_DEF  = 10;
    localparam int  QUARTER = 2 ** (AW_DEF - 2);
    localparam real PI      = 3.14159265358979323846;

    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Symmetric amplitude, so the most negative code is never produced.
    function automatic int lut_val(input int k, input int aw, input int ow);
        real amp;
        real x;
        amp = real'((2 ** (ow - 1)) - 1);
        x   = amp * $cos(2.0 * PI * real'(k) / real'(2 ** aw));
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(0.5 - x);
    endfunction
endpackage

// File: rtl/dds_mc_nco_if.sv
// dds_mc_nco_if: control and sample bus of the multi-channel NCO.
//   master : en, wr, wch, wfrq, wclr out; doxy, dch, diq, dv, busy, ovr in
//   slave  : the NCO side (directions reversed)
interface dds_mc_nco_if #(
    parameter int NCH = 4,
    parameter int PW  = 32,
    parameter int OW  = 18
);
    import dds_mc_pkg::*;
    localparam int CW = ch_width(NCH);

    logic          en;
    logic          wr;
    logic [CW-1:0] wch;
    logic [PW-1:0] wfrq;
    logic          wclr;
    logic [OW-1:0] doxy;
    logic [CW-1:0] dch;
    logic          diq;
    logic          dv;
    logic          busy;
    logic          ovr;

    modport master (output en, wr, wch, wfrq, wclr,
                    input  doxy, dch, diq, dv, busy, ovr);
    modport slave  (input  en, wr, wch, wfrq, wclr,
                    output doxy, dch, diq, dv, busy, ovr);
endinterface

// File: rtl/dds_sincos_lut.sv
// dds_sincos_lut: 2^AW x OW cosine ROM, synchronous read, one-cycle latency.
//   clk    : clock
//   addr_i : phase address (full cycle = 2^AW points)
//   data_o : signed cosine sample, registered
module dds_sincos_lut #(
    parameter int AW = 10,
    parameter int OW = 18
) (
    input  logic          clk,
    input  logic [AW-1:0] addr_i,
    output logic [OW-1:0] data_o
);
    import dds_mc_pkg::*;

    logic [OW-1:0] rom [2**AW];

    // Each entry is an elaboration-time constant, so this folds into a ROM.
    for (genvar k = 0; k < 2**AW; k++) begin : g_rom
        localparam int V = lut_val(k, AW, OW);
        assign rom[k] = OW'(V);
    end

    always_ff @(posedge clk) data_o <= rom[addr_i];
endmodule

// File: rtl/dds_mc_nco.sv
// dds_mc_nco: time-multiplexed NCH-channel NCO sharing one cosine LUT.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : dds_mc_nco_if.slave -- en/wr/wch/wfrq/wclr in,
//              doxy/dch/diq/dv/busy/ovr out
// Each accepted en emits ch0 I, ch0 Q, ... ch(NCH-1) Q, one word per clock,
// first word 3 cycles after en (phase select, LUT read, output register).
// Optional: DDS_MC_NCO_DITHER_EN adds a per-frame LFSR value below the
// truncation point of the phase before LUT addressing.
module dds_mc_nco #(
    parameter int NCH = 4,
    parameter int PW  = 32,
    parameter int AW  = 10,
    parameter int OW  = 18
) (
    input  logic              clk,
    input  logic              rst,
    dds_mc_nco_if.slave       bus
);
    import dds_mc_pkg::*;

    localparam int              CW     = ch_width(NCH);
    localparam int              SW     = CW + 1;
    localparam int              STAGES = 3;
    localparam logic [SW-1:0]   LAST   = SW'(2 * NCH - 1);
    localparam logic [AW-1:0]   QTR    = AW'(2 ** (AW - 2));

    logic [NCH-1:0][PW-1:0] acc_q, frq_q, shd_q;
    logic [NCH-1:0]         pclr_q;
    logic                   busy_q, ovr_q;
    logic [SW-1:0]          slot_q;
    logic                   start;
    logic [CW-1:0]          cur_ch;
    logic                   cur_iq;
    logic [PW-1:0]          phs;
    logic [AW-1:0]          addr_d, addr_q;
    logic [STAGES-1:0]      vld_pipe_q;
    logic [CW-1:0]          ch1_q, ch2_q, dch_q;
    logic                   iq1_q, iq2_q, diq_q;
    logic [OW-1:0]          lut_data, doxy_q;

    assign start  = bus.en && !busy_q;
    // Slot index = {channel, I/Q}
    assign cur_ch = slot_q[SW-1:1];
    assign cur_iq = slot_q[0];

`ifdef DDS_MC_NCO_DITHER_EN
    logic [23:0] lfsr_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        lfsr_q <= 24'd1;
        else if (start) lfsr_q <= {lfsr_q[22:0],
                                   lfsr_q[23] ^ lfsr_q[22] ^ lfsr_q[21] ^ lfsr_q[16]};
    end
    assign phs = acc_q[cur_ch] + PW'(lfsr_q[PW-AW-1:0]);
`else
    assign phs = acc_q[cur_ch];
`endif

    // Q slot reads a quarter cycle earlier: sin(x) = cos(x - 90 deg).
    always_comb begin
        addr_d = AW'(phs >> (PW - AW));
        if (cur_iq) addr_d = addr_d - QTR;
    end

    // Frame sequencer and overrun flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            ovr_q  <= 1'b0;
            slot_q <= '0;
        end else begin
            if (bus.en && busy_q) ovr_q <= 1'b1;
            if (start) begin
                busy_q <= 1'b1;
                slot_q <= '0;
            end else if (busy_q) begin
                slot_q <= slot_q + SW'(1);
                if (slot_q == LAST) busy_q <= 1'b0;
            end
        end
    end

    // Accumulators, shadow/active frequency words, pending clears.
    // A write in the frame-start cycle lands in shadow after the copy,
    // so it takes effect on the following frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            frq_q  <= '0;
            shd_q  <= '0;
            pclr_q <= '0;
        end else begin
            if (start) begin
                frq_q  <= shd_q;
                pclr_q <= '0;
                for (int c = 0; c < NCH; c++)
                    if (pclr_q[c]) acc_q[c] <= '0;
            end
            // Advance after the channel's Q slot; wrap is modulo 2^PW.
            if (busy_q && cur_iq)
                acc_q[cur_ch] <= acc_q[cur_ch] + frq_q[cur_ch];
            if (bus.wr) begin
                shd_q[bus.wch]  <= bus.wfrq;
                pclr_q[bus.wch] <= bus.wclr;
            end
        end
    end

    dds_sincos_lut #(.AW(AW), .OW(OW)) u_lut (
        .clk    (clk),
        .addr_i (addr_q),
        .data_o (lut_data)
    );

    // Three-stage pipe: [0] address registered, [1] LUT data, [2] output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe_q <= '0;
            addr_q     <= '0;
            ch1_q      <= '0;
            iq1_q      <= 1'b0;
            ch2_q      <= '0;
            iq2_q      <= 1'b0;
            doxy_q     <= '0;
            dch_q      <= '0;
            diq_q      <= 1'b0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[STAGES-2:0], busy_q};
            addr_q     <= addr_d;
            ch1_q      <= cur_ch;
            iq1_q      <= cur_iq;
            ch2_q      <= ch1_q;
            iq2_q      <= iq1_q;
            if (vld_pipe_q[1]) begin
                doxy_q <= lut_data;
                dch_q  <= ch2_q;
                diq_q  <= iq2_q;
            end
        end
    end

    assign bus.doxy = doxy_q;
    assign bus.dch  = dch_q;
    assign bus.diq  = diq_q;
    assign bus.dv   = vld_pipe_q[STAGES-1];
    assign bus.busy = busy_q;
    assign bus.ovr  = ovr_q;
endmodule

// File: tb/tb_dds_mc_nco.sv
module tb_dds_mc_nco;
    localparam int NCH = 4;
    localparam int PW  = 32;
    localparam int AW  = 10;
    localparam int OW  = 18;
    localparam int A   = 131071;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dds_mc_nco_if #(.NCH(NCH), .PW(PW), .OW(OW)) bus ();

    dds_mc_nco #(.NCH(NCH), .PW(PW), .AW(AW), .OW(OW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: per-channel phase, active/shadow word, pending clear
    logic [31:0] m_acc [NCH];
    logic [31:0] m_frq [NCH];
    logic [31:0] m_shd [NCH];
    bit          m_pend[NCH];
    int          obs   [2*NCH];

    function automatic int ref_val(logic [31:0] p, bit q);
        int  k;
        real x;
        k = int'(p[31:22]);
        if (q) k = (k - 256) & 1023;
        x = real'(A) * $cos(2.0 * 3.14159265358979323846 * real'(k) / 1024.0);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    endfunction

    task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(o), $signed(e));
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_acc[c] = '0; m_frq[c] = '0; m_shd[c] = '0; m_pend[c] = 1'b0;
        end
    endtask

    task automatic model_start();
        for (int c = 0; c < NCH; c++) begin
            m_frq[c] = m_shd[c];
            if (m_pend[c]) m_acc[c] = '0;
            m_pend[c] = 1'b0;
        end
    endtask

    task automatic do_write(int c, logic [31:0] f, bit clr);
        bus.wr = 1'b1; bus.wch = 2'(c); bus.wfrq = f; bus.wclr = clr;
        @(negedge clk);
        bus.wr = 1'b0; bus.wclr = 1'b0;
        m_shd[c] = f; m_pend[c] = clr;
    endtask

    // One frame; ov_at >= 0 pulses a second en during the frame,
    // sc_wr issues a write in the same cycle as the accepted en.
    task automatic frame(int ov_at, bit sc_wr, int sc_ch, logic [31:0] sc_f, bit sc_clr);
        int j, c;
        bit q;
        bus.en = 1'b1;
        if (sc_wr) begin
            bus.wr = 1'b1; bus.wch = 2'(sc_ch); bus.wfrq = sc_f; bus.wclr = sc_clr;
        end
        model_start();
        if (sc_wr) begin m_shd[sc_ch] = sc_f; m_pend[sc_ch] = sc_clr; end
        @(negedge clk);
        bus.en = 1'b0; bus.wr = 1'b0; bus.wclr = 1'b0;
        for (int k = 0; k < 2*NCH + 4; k++) begin
            bus.en = (k == ov_at);
            chk("busy", 32'(bus.busy), 32'(k < 2*NCH));
            chk("dv", 32'(bus.dv), 32'(k >= 3 && k < 3 + 2*NCH));
            if (k >= 3 && k < 3 + 2*NCH) begin
                j = k - 3; c = j / 2; q = j[0];
                obs[j] = 32'($signed(bus.doxy));
                chk("doxy", 32'($signed(bus.doxy)), 32'(ref_val(m_acc[c], q)));
                chk("dch", 32'(bus.dch), 32'(c));
                chk("diq", 32'(bus.diq), 32'(q));
            end
            @(negedge clk);
        end
        bus.en = 1'b0;
        for (int ch = 0; ch < NCH; ch++) m_acc[ch] = m_acc[ch] + m_frq[ch];
    endtask

    int tI[4] = '{A, 0, -A, 0};
    int tQ[4] = '{0, A, 0, -A};
    int p0I, p0Q;

    initial begin
        bus.en = 1'b0; bus.wr = 1'b0; bus.wch = '0; bus.wfrq = '0; bus.wclr = 1'b0;
        model_reset();
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_doxy", 32'(bus.doxy), 0);
        chk("rst_dv", 32'(bus.dv), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_ovr", 32'(bus.ovr), 0);
        chk("rst_dch", 32'(bus.dch), 0);
        chk("rst_diq", 32'(bus.diq), 0);

        // All frequencies zero: every channel I = full scale, Q = 0
        frame(-1, 0, 0, '0, 0);
        for (int c = 0; c < NCH; c++) begin
            chk("f0_I", 32'(obs[2*c]), 32'(A));
            chk("f0_Q", 32'(obs[2*c+1]), 0);
        end

        // Quarter-cycle step on ch1
        do_write(1, 32'h4000_0000, 0);
        for (int f = 0; f < 4; f++) begin
            frame(-1, 0, 0, '0, 0);
            chk("ch1_I", 32'(obs[2]), 32'(tI[f]));
            chk("ch1_Q", 32'(obs[3]), 32'(tQ[f]));
            chk("ch0_I", 32'(obs[0]), 32'(A));
        end

        // en during a frame, then en on the last busy cycle
        chk("ovr_pre", 32'(bus.ovr), 0);
        frame(2, 0, 0, '0, 0);
        chk("ovr_set", 32'(bus.ovr), 1);
        frame(2*NCH - 1, 0, 0, '0, 0);
        chk("ovr_sticky", 32'(bus.ovr), 1);

        // ch2 period 256 frames, wraps past 2^32
        do_write(2, 32'h0100_0000, 0);
        for (int f = 0; f <= 256; f++) begin
            frame(-1, 0, 0, '0, 0);
            if (f == 0) begin p0I = obs[4]; p0Q = obs[5]; end
            if (f == 128) chk("ch2_half", 32'(obs[4]), 32'(-A));
            if (f == 256) begin
                chk("ch2_perI", 32'(obs[4]), 32'(p0I));
                chk("ch2_perQ", 32'(obs[5]), 32'(p0Q));
            end
        end

        // Retune without clear (continuous), then with clear
        do_write(2, 32'h0010_0000, 0);
        frame(-1, 0, 0, '0, 0);
        frame(-1, 0, 0, '0, 0);
        do_write(2, 32'h0030_0000, 1);
        frame(-1, 0, 0, '0, 0);
        chk("clr_I", 32'(obs[4]), 32'(A));
        chk("clr_Q", 32'(obs[5]), 0);

        // Last write wins
        do_write(3, 32'h1111_1111, 1);
        do_write(3, 32'h2000_0000, 0);
        frame(-1, 0, 0, '0, 0);
        frame(-1, 0, 0, '0, 0);

        // Write in the en cycle applies to the next frame
        frame(-1, 1, 0, 32'h0800_0000, 1);
        frame(-1, 0, 0, '0, 0);
        chk("sc_I", 32'(obs[0]), 32'(A));
        frame(-1, 0, 0, '0, 0);

        // Randomized writes and frames
        for (int it = 0; it < 40; it++) begin
            for (int w = 0; w < int'($urandom_range(0, 2)); w++)
                do_write(int'($urandom_range(0, NCH-1)), $urandom(), $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0)
                frame(-1, 1, int'($urandom_range(0, NCH-1)), $urandom(), $urandom_range(0, 1) == 1);
            else
                frame(-1, 0, 0, '0, 0);
        end

        // Reset during the 5th word of a frame
        bus.en = 1'b1;
        model_start();
        @(negedge clk);
        bus.en = 1'b0;
        repeat (7) @(negedge clk);
        chk("mid_dv", 32'(bus.dv), 1);
        chk("mid_dch", 32'(bus.dch), 2);
        rst = 1'b1;
        #1;
        chk("arst_dv", 32'(bus.dv), 0);
        chk("arst_doxy", 32'(bus.doxy), 0);
        chk("arst_busy", 32'(bus.busy), 0);
        chk("arst_ovr", 32'(bus.ovr), 0);
        chk("arst_dch", 32'(bus.dch), 0);
        chk("arst_diq", 32'(bus.diq), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        frame(-1, 0, 0, '0, 0);
        for (int c = 0; c < NCH; c++) begin
            chk("post_I", 32'(obs[2*c]), 32'(A));
            chk("post_Q", 32'(obs[2*c+1]), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
